// File: rtl/game_pkg.sv
// Shared types and constants for the game restart sequencing.
// Restart codes, restart FSM states, spawn positions and score limit.
package game_pkg;

    typedef enum logic [1:0] {
        RST_NONE      = 2'b00,
        RST_TOM_WIN   = 2'b01,
        RST_JERRY_WIN = 2'b10,
        RST_MANUAL    = 2'b11
    } restart_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FREEZE = 2'd1,
        CLEAR  = 2'd2,
        SPAWN  = 2'd3
    } state_e;

    localparam logic [9:0] TOM_SPAWN_X   = 10'd64;
    localparam logic [9:0] TOM_SPAWN_Y   = 10'd400;
    localparam logic [9:0] JERRY_SPAWN_X = 10'd560;
    localparam logic [9:0] JERRY_SPAWN_Y = 10'd80;

    localparam logic [3:0] SCORE_MAX = 4'd9;

endpackage

// File: rtl/score_counter.sv
// Saturating round-win counter for one character.
// Clear has priority over increment.
module score_counter
    import game_pkg::*;
#(
    parameter logic [3:0] MAX = SCORE_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count < MAX)) begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/game_restart.sv
// Restart sequencer: freeze, clear handshake, spawn pulse, round scores.
// Frame and ack-timeout timers are kept here alongside the FSM.
module game_restart
    import game_pkg::*;
#(
    parameter int FREEZE_FRAMES = 120,
    parameter int ACK_TIMEOUT   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] reset_req,
    input  logic       frame_tick,
    input  logic       clear_ack,
    output logic       game_freeze,
    output logic       clear_req,
    output logic       spawn_load,
    output logic [1:0] winner,
    output logic [3:0] tom_score,
    output logic [3:0] jerry_score,
    output logic       busy,
    output logic       ack_timeout
);

    localparam int FW = (FREEZE_FRAMES > 0) ? $clog2(FREEZE_FRAMES + 1) : 1;
    localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FREEZE_FRAMES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(ACK_TIMEOUT - 1);

    state_e state_q, state_d;
    restart_e req;

    logic [FW-1:0] frame_cnt;
    logic [TW-1:0] to_cnt;

    logic tom_inc, jerry_inc, score_clr;
    logic winner_ld, timeout_set, timeout_clr;
    logic frame_last, to_last;

    assign req        = restart_e'(reset_req);
    assign frame_last = (frame_cnt == FRAME_LAST);
    assign to_last    = (ACK_TIMEOUT == 0) || (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tom_inc     = 1'b0;
        jerry_inc   = 1'b0;
        score_clr   = 1'b0;
        winner_ld   = 1'b0;
        timeout_set = 1'b0;
        timeout_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                unique case (req)
                    RST_TOM_WIN, RST_JERRY_WIN: begin
                        winner_ld = 1'b1;
                        tom_inc   = (req == RST_TOM_WIN);
                        jerry_inc = (req == RST_JERRY_WIN);
                        state_d   = (FREEZE_FRAMES == 0) ? CLEAR : FREEZE;
                    end
                    RST_MANUAL: begin
                        winner_ld   = 1'b1;
                        score_clr   = 1'b1;
                        timeout_clr = 1'b1;
                        state_d     = CLEAR;
                    end
                    default: ;
                endcase
            end
            FREEZE: begin
                // Manual beats a coincident terminal tick
                if (req == RST_MANUAL) begin
                    winner_ld   = 1'b1;
                    score_clr   = 1'b1;
                    timeout_clr = 1'b1;
                    state_d     = CLEAR;
                end else if (frame_tick && frame_last) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (clear_ack) begin
                    state_d = SPAWN;
                end else if (to_last) begin
                    timeout_set = 1'b1;
                    state_d     = SPAWN;
                end
            end
            SPAWN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters idle at zero outside their state, so entry always starts at 0
    always_ff @(posedge clk) begin
        if (rst || (state_q != FREEZE)) begin
            frame_cnt <= '0;
        end else if (frame_tick) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (state_q != CLEAR)) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            winner      <= 2'b00;
            ack_timeout <= 1'b0;
        end else begin
            if (winner_ld) begin
                winner <= reset_req;
            end
            if (timeout_clr) begin
                ack_timeout <= 1'b0;
            end else if (timeout_set) begin
                ack_timeout <= 1'b1;
            end
        end
    end

    score_counter #(.MAX(SCORE_MAX)) u_tom_score (
        .clk   (clk),
        .rst   (rst),
        .inc   (tom_inc),
        .clr   (score_clr),
        .count (tom_score)
    );

    score_counter #(.MAX(SCORE_MAX)) u_jerry_score (
        .clk   (clk),
        .rst   (rst),
        .inc   (jerry_inc),
        .clr   (score_clr),
        .count (jerry_score)
    );

    assign busy        = (state_q != IDLE);
    assign game_freeze = busy;
    assign clear_req   = (state_q == CLEAR);
    assign spawn_load  = (state_q == SPAWN);

endmodule

// File: doc/game_restart.md
# game_restart

Consumer of the 2-bit restart code produced by the game's reset-request logic. It latches a round-end or manual restart request and freezes gameplay for a fixed number of frames so the result can be shown. It then commands the movement/position modules to clear, waits for their acknowledge, and pulses a spawn load. It also keeps the per-character round scores shown by the HUD.

## Interface
Parameters:
- FREEZE_FRAMES, default 120: number of `frame_tick` pulses the game stays frozen after a round end. 0 means no freeze.
- ACK_TIMEOUT, default 16: maximum cycles to wait for `clear_ack` before proceeding anyway.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- reset_req  in  2  restart code, sampled every cycle:
  - 00: none
  - 01: Tom caught Jerry
  - 10: Jerry escaped
  - 11: manual button
- frame_tick  in  1  one-cycle pulse per video frame (vsync)
- clear_ack  in  1  level from position/movement modules; high means cleared
- game_freeze  out  1  high while any restart is in progress; movement modules hold state
- clear_req  out  1  level, held for the whole CLEAR state
- spawn_load  out  1  one-cycle pulse; modules load spawn positions from game_pkg
- winner  out  2  code of the last accepted request; held until the next request
- tom_score  out  4  Tom round wins, saturating at 9
- jerry_score  out  4  Jerry round wins, saturating at 9
- busy  out  1  high when not in IDLE
- ack_timeout  out  1  sticky; set when CLEAR exits by timeout, cleared by rst or manual request

## Operation
State machine with four states: IDLE, FREEZE, CLEAR, SPAWN.

IDLE:
- `reset_req` = 01 or 10: latch it into `winner`; increment `tom_score` (01) or `jerry_score` (10), saturating at 9; go to FREEZE.
- If FREEZE_FRAMES = 0, go directly to CLEAR instead.
- `reset_req` = 11: `winner` = 11, both scores = 0, `ack_timeout` = 0, go to CLEAR. Manual restart has no freeze.

FREEZE:
- Count `frame_tick` pulses.
- On the FREEZE_FRAMES-th tick, go to CLEAR on the next edge.
- `reset_req` = 11 aborts the freeze: apply the manual actions above, go to CLEAR.
- `reset_req` = 01/10 is ignored.

CLEAR:
- `clear_req` = 1.
- Go to SPAWN on the first cycle `clear_ack` = 1.
- If the timeout counter reaches ACK_TIMEOUT with no ack: set `ack_timeout`, go to SPAWN.
- All `reset_req` values are ignored.

SPAWN:
- `spawn_load` = 1 for exactly this one cycle; go to IDLE.
- `reset_req` is ignored.

Outputs:
- `game_freeze` = `busy` = (state ≠ IDLE).
- Frame counter width is $clog2(FREEZE_FRAMES+1). Timeout counter width is $clog2(ACK_TIMEOUT+1).
- Both counters are cleared on entry to their state.
- A `reset_req` held non-zero across the return to IDLE is accepted again. The source must deassert.

## Timing
- Values after reset: state IDLE, all outputs 0.
- Request sampled in IDLE at edge N: `busy`, `game_freeze`, `winner` and scores update at edge N (visible in cycle N+1).
- FREEZE exits on the edge following the cycle containing the final `frame_tick`.
- A `frame_tick` in the same cycle as FREEZE entry is not counted.
- `clear_req` rises on the edge entering CLEAR.
- If `clear_ack` is already high on the first CLEAR cycle, SPAWN is entered on the next edge. Minimum `clear_req` width is 1 cycle.
- Timeout: with no ack, SPAWN is entered after exactly ACK_TIMEOUT cycles in CLEAR.
- `spawn_load` is high for 1 cycle. `game_freeze` drops on the edge after `spawn_load`.
- Manual restart latency from IDLE to first `clear_req` = 1 cycle.
- Manual and `frame_tick` terminal count in the same FREEZE cycle: manual takes priority; scores are zeroed.
- `rst` mid-sequence: returns to IDLE next edge; all outputs and scores are 0, including `clear_req` and `spawn_load`.

## Structure
- game_pkg contains:
  - typedef enum of restart codes: RST_NONE, RST_TOM_WIN, RST_JERRY_WIN, RST_MANUAL.
  - State enum: IDLE, FREEZE, CLEAR, SPAWN.
  - Spawn positions: TOM_SPAWN_X/Y, JERRY_SPAWN_X/Y.
  - SCORE_MAX = 9.
- Sub-module `score_counter`: 4-bit saturating counter with increment, clear and max. Instantiated twice, once per character.
- The FSM and both timers live in the top module.

## Test plan
- Bench parameters: FREEZE_FRAMES = 3, ACK_TIMEOUT = 4.
- Tom win: `reset_req` = 01 for 1 cycle, 3 `frame_tick` pulses, `clear_ack` held high → `tom_score` = 1, `winner` = 01, `clear_req` high for 1 cycle, single `spawn_load` pulse, `game_freeze` low 1 cycle after the pulse.
- Saturation: 10 Jerry wins → `jerry_score` = 9 after the 9th and 10th; `tom_score` unchanged.
- Manual abort: Tom win, then `reset_req` = 11 after 1 tick → both scores = 0, `winner` = 11, `clear_req` rises next edge, no further freeze.
- Ack timeout: `clear_ack` held 0 → `clear_req` high exactly 4 cycles, then `spawn_load`, `ack_timeout` = 1 and held; next manual request clears it.
- Ignored requests: `reset_req` = 01 during CLEAR and SPAWN → no score change, sequence timing unchanged.
- Reset mid-operation: `rst` during CLEAR → next cycle all outputs 0, state IDLE; a subsequent 10 request gives `jerry_score` = 1.
